// File: rtl/sram4x2_pkg.sv
// Shared constants for the 4x2 SRAM arbiter: FSM encoding, default widths, chip-select levels.
package sram4x2_pkg;

  localparam int ADDR_W_DEF = 2;
  localparam int DATA_W_DEF = 2;

  localparam logic CS_WRITE = 1'b1;
  localparam logic CS_READ  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_DONE   = 3'd3,
    ST_VERIFY = 3'd4
  } state_e;

endpackage

// File: rtl/sram4x2_arbiter_rr_arb2.sv
// Combinational 2-way round-robin grant; the priority pointer is owned by the parent.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = i_ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/sram4x2_arbiter.sv
// Two-port round-robin controller for the 4x2 latch-cell SRAM: setup/strobe/done sequencing.
// Optional write read-back check enabled by defining SRAM4X2_WR_VERIFY_EN (adds o_wr_err).
module sram4x2_arbiter
  import sram4x2_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [1:0]        i_req,
  input  logic [1:0]        i_we,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic [1:0]        o_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_d,
  output logic              o_sram_en,
  output logic              o_sram_cs,
  input  logic [DATA_W-1:0] i_sram_q,
`ifdef SRAM4X2_WR_VERIFY_EN
  output logic              o_wr_err,
`endif
  output logic [2:0]        o_dbg_state
);

  state_e              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic                gnt_port_q, gnt_port_d;
  logic                we_q, we_d;
  logic [1:0]          ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0]   sram_d_q, sram_d_d;
  logic                sram_en_q, sram_en_d;
  logic                sram_cs_q, sram_cs_d;
  logic [1:0]          gnt;
`ifdef SRAM4X2_WR_VERIFY_EN
  logic                wr_err_q, wr_err_d;
`endif

  rr_arb2 u_arb (
    .i_req (i_req),
    .i_ptr (ptr_q),
    .o_gnt (gnt)
  );

  // The array address/data registers double as the latched request, so they only
  // move at grant time while the enable is still low.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_port_d  = gnt_port_q;
    we_d        = we_q;
    ack_d       = 2'b00;
    rdata_d     = rdata_q;
    sram_addr_d = sram_addr_q;
    sram_d_d    = sram_d_q;
    sram_en_d   = sram_en_q;
    sram_cs_d   = sram_cs_q;
`ifdef SRAM4X2_WR_VERIFY_EN
    wr_err_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          gnt_port_d  = gnt[1];
          we_d        = gnt[1] ? i_we[1] : i_we[0];
          sram_addr_d = gnt[1] ? i_addr1 : i_addr0;
          sram_d_d    = gnt[1] ? i_wdata1 : i_wdata0;
          sram_cs_d   = (gnt[1] ? i_we[1] : i_we[0]) ? CS_WRITE : CS_READ;
          sram_en_d   = 1'b0;
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        sram_en_d = 1'b1;
        state_d   = ST_STROBE;
      end
      ST_STROBE: begin
        if (!we_q) begin
          rdata_d = i_sram_q;
        end
`ifdef SRAM4X2_WR_VERIFY_EN
        if (we_q) begin
          sram_cs_d = CS_READ;
          sram_en_d = 1'b1;
          state_d   = ST_VERIFY;
        end else begin
          sram_cs_d = CS_WRITE;
          sram_en_d = 1'b0;
          ack_d     = gnt_port_q ? 2'b10 : 2'b01;
          state_d   = ST_DONE;
        end
`else
        sram_cs_d = CS_WRITE;
        sram_en_d = 1'b0;
        ack_d     = gnt_port_q ? 2'b10 : 2'b01;
        state_d   = ST_DONE;
`endif
      end
`ifdef SRAM4X2_WR_VERIFY_EN
      ST_VERIFY: begin
        wr_err_d  = (i_sram_q != sram_d_q);
        sram_cs_d = CS_WRITE;
        sram_en_d = 1'b0;
        ack_d     = gnt_port_q ? 2'b10 : 2'b01;
        state_d   = ST_DONE;
      end
`endif
      ST_DONE: begin
        ptr_d   = ~gnt_port_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      gnt_port_q  <= 1'b0;
      we_q        <= 1'b0;
      ack_q       <= 2'b00;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      sram_addr_q <= '0;
      sram_d_q    <= '0;
      sram_en_q   <= 1'b0;
      sram_cs_q   <= CS_WRITE;
`ifdef SRAM4X2_WR_VERIFY_EN
      wr_err_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_port_q  <= gnt_port_d;
      we_q        <= we_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      sram_addr_q <= sram_addr_d;
      sram_d_q    <= sram_d_d;
      sram_en_q   <= sram_en_d;
      sram_cs_q   <= sram_cs_d;
`ifdef SRAM4X2_WR_VERIFY_EN
      wr_err_q    <= wr_err_d;
`endif
    end
  end

  assign o_ack       = ack_q;
  assign o_rdata     = rdata_q;
  assign o_busy      = busy_q;
  assign o_sram_addr = sram_addr_q;
  assign o_sram_d    = sram_d_q;
  assign o_sram_en   = sram_en_q;
  assign o_sram_cs   = sram_cs_q;
  assign o_dbg_state = state_q;
`ifdef SRAM4X2_WR_VERIFY_EN
  assign o_wr_err    = wr_err_q;
`endif

endmodule

// File: tb/tb_sram4x2_arbiter.sv
// Self-checking bench for sram4x2_arbiter with a behavioural 4x2 array model.
`timescale 1ns/1ps
module tb_sram4x2_arbiter;
  import sram4x2_pkg::*;

  localparam int W = 3;
  localparam int RD_EDGES = 3;
`ifdef SRAM4X2_WR_VERIFY_EN
  localparam int WR_EDGES  = 4;
  localparam int WR_EN_CYC = 2;
`else
  localparam int WR_EDGES  = 3;
  localparam int WR_EN_CYC = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] we = 2'b00;
  logic [1:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [1:0] ack, rdata, sram_addr, sram_d, sram_q;
  logic       busy, sram_en, sram_cs;
  logic [2:0] dbg_state;
  logic       wr_err;
  logic       verify_bad = 1'b0;

  logic [1:0] mem [4];
  logic [1:0] ref_mem [4];
  logic [1:0] rdata_model = 2'b00;
  logic [W-1:0] exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int en_total = 0;
  int ack_total = 0;
  int glitch_total = 0;
  logic       prev_en = 1'b0;
  logic [3:0] prev_ad = '0;

  always #5 clk = ~clk;

  sram4x2_arbiter dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_we        (we),
    .i_addr0     (addr0),
    .i_addr1     (addr1),
    .i_wdata0    (wdata0),
    .i_wdata1    (wdata1),
    .o_ack       (ack),
    .o_rdata     (rdata),
    .o_busy      (busy),
    .o_sram_addr (sram_addr),
    .o_sram_d    (sram_d),
    .o_sram_en   (sram_en),
    .o_sram_cs   (sram_cs),
    .i_sram_q    (sram_q),
`ifdef SRAM4X2_WR_VERIFY_EN
    .o_wr_err    (wr_err),
`endif
    .o_dbg_state (dbg_state)
  );

`ifndef SRAM4X2_WR_VERIFY_EN
  assign wr_err = 1'b0;
`endif

  // Array model: stores D while enabled with cs=1, drives Q while enabled with cs=0.
  always @(posedge clk) begin
    if (sram_en && sram_cs == CS_WRITE) mem[sram_addr] <= sram_d;
  end
  assign sram_q = (sram_en && sram_cs == CS_READ) ? (verify_bad ? 2'b01 : mem[sram_addr]) : 2'b00;

  always @(negedge clk) begin
    if (sram_en) en_total <= en_total + 1;
    if (ack != 2'b00) ack_total <= ack_total + 1;
    if (sram_en && prev_en && ({sram_addr, sram_d} != prev_ad)) glitch_total <= glitch_total + 1;
    prev_en <= sram_en;
    prev_ad <= {sram_addr, sram_d};
  end

  task automatic idle_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_port(input int p, input logic w, input logic [1:0] a, input logic [1:0] d);
    if (p == 0) begin
      we[0] = w; addr0 = a; wdata0 = d; req[0] = 1'b1;
    end else begin
      we[1] = w; addr1 = a; wdata1 = d; req[1] = 1'b1;
    end
  endtask

  task automatic push_exp(input int p, input logic w, input logic [1:0] a, input logic [1:0] d);
    if (w) ref_mem[a] = d;
    else rdata_model = ref_mem[a];
    exp_q.push_back({p[0], rdata_model});
  endtask

  task automatic wait_ack(input int max_edges, output logic [1:0] a, output int edges);
    a = 2'b00;
    edges = -1;
    for (int i = 1; i <= max_edges; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack != 2'b00) begin
        a = ack;
        edges = i;
        break;
      end
    end
  endtask

  task automatic single_access(input int p, input logic w, input logic [1:0] a, input logic [1:0] d,
                               output logic [1:0] got, output int edges, output int en_cyc);
    int en0;
    idle_cycle();
    en0 = en_total;
    set_port(p, w, a, d);
    push_exp(p, w, a, d);
    wait_ack(8, got, edges);
    req = 2'b00;
    en_cyc = en_total - en0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (ack !== 2'b00) begin n_err++; $display("FAIL rst_ack: got %b want 00", ack); end
    n_cmp++; if (rdata !== 2'b00) begin n_err++; $display("FAIL rst_rdata: got %b want 00", rdata); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (sram_en !== 1'b0) begin n_err++; $display("FAIL rst_en: got %b want 0", sram_en); end
    n_cmp++; if (sram_cs !== 1'b1) begin n_err++; $display("FAIL rst_cs: got %b want 1", sram_cs); end
    n_cmp++; if ({sram_addr, sram_d} !== 4'b0000) begin n_err++; $display("FAIL rst_addr_d: got %b want 0000", {sram_addr, sram_d}); end
    n_cmp++; if (dbg_state !== 3'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    logic [1:0] got; int edges, en_cyc; logic [W-1:0] e;
    single_access(0, 1'b1, 2'd2, 2'b10, got, edges, en_cyc);
    e = exp_q.pop_front();
    n_cmp++; if (got !== 2'b01) begin n_err++; $display("FAIL wr_ack: got %b want 01", got); end
    n_cmp++; if (edges !== WR_EDGES) begin n_err++; $display("FAIL wr_latency: got %0d want %0d", edges, WR_EDGES); end
    n_cmp++; if (rdata !== e[1:0]) begin n_err++; $display("FAIL wr_rdata_hold: got %b want %b", rdata, e[1:0]); end
    n_cmp++; if (en_cyc !== WR_EN_CYC) begin n_err++; $display("FAIL wr_en_cycles: got %0d want %0d", en_cyc, WR_EN_CYC); end
    single_access(0, 1'b0, 2'd2, 2'b00, got, edges, en_cyc);
    e = exp_q.pop_front();
    n_cmp++; if (got !== 2'b01) begin n_err++; $display("FAIL rd_ack: got %b want 01", got); end
    n_cmp++; if (edges !== RD_EDGES) begin n_err++; $display("FAIL rd_latency: got %0d want %0d", edges, RD_EDGES); end
    n_cmp++; if (rdata !== e[1:0]) begin n_err++; $display("FAIL rd_data: got %b want %b", rdata, e[1:0]); end
    n_cmp++; if (en_cyc !== 1) begin n_err++; $display("FAIL rd_en_cycles: got %0d want 1", en_cyc); end
  endtask

  task automatic test_round_robin();
    logic [1:0] got; int edges, en_cyc; logic [W-1:0] e;
    single_access(0, 1'b1, 2'd0, 2'b01, got, edges, en_cyc);
    e = exp_q.pop_front();
    n_cmp++; if (got !== 2'b01) begin n_err++; $display("FAIL pre0_ack: got %b want 01", got); end
    single_access(1, 1'b1, 2'd3, 2'b11, got, edges, en_cyc);
    e = exp_q.pop_front();
    n_cmp++; if (got !== 2'b10) begin n_err++; $display("FAIL pre1_ack: got %b want 10", got); end
    idle_cycle();
    set_port(0, 1'b0, 2'd0, 2'b00);
    set_port(1, 1'b0, 2'd3, 2'b00);
    for (int i = 0; i < 4; i++) push_exp(i % 2, 1'b0, (i % 2 == 0) ? 2'd0 : 2'd3, 2'b00);
    for (int i = 0; i < 4; i++) begin
      wait_ack(8, got, edges);
      e = exp_q.pop_front();
      n_cmp++; if (got !== (e[2] ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL rr_ack%0d: got %b want %b", i, got, e[2] ? 2'b10 : 2'b01); end
      n_cmp++; if (rdata !== e[1:0]) begin n_err++; $display("FAIL rr_rdata%0d: got %b want %b", i, rdata, e[1:0]); end
      n_cmp++; if (edges !== ((i == 0) ? RD_EDGES : 4)) begin n_err++; $display("FAIL rr_spacing%0d: got %0d want %0d", i, edges, (i == 0) ? RD_EDGES : 4); end
    end
    req = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic [1:0] got; int edges; logic [W-1:0] e;
    logic [1:0] a_tab [3];
    logic [1:0] d_tab [3];
    a_tab = '{2'd1, 2'd2, 2'd3};
    d_tab = '{2'b11, 2'b01, 2'b10};
    idle_cycle();
    for (int i = 0; i < 3; i++) begin
      set_port(1, 1'b1, a_tab[i], d_tab[i]);
      push_exp(1, 1'b1, a_tab[i], d_tab[i]);
      wait_ack(8, got, edges);
      e = exp_q.pop_front();
      n_cmp++; if (got !== 2'b10) begin n_err++; $display("FAIL b2b_ack%0d: got %b want 10", i, got); end
      n_cmp++; if (edges !== ((i == 0) ? WR_EDGES : WR_EDGES + 1)) begin n_err++; $display("FAIL b2b_spacing%0d: got %0d want %0d", i, edges, (i == 0) ? WR_EDGES : WR_EDGES + 1); end
    end
    req = 2'b00;
    idle_cycle();
    set_port(0, 1'b0, 2'd2, 2'b00);
    set_port(1, 1'b0, 2'd3, 2'b00);
    push_exp(0, 1'b0, 2'd2, 2'b00);
    push_exp(1, 1'b0, 2'd3, 2'b00);
    for (int i = 0; i < 2; i++) begin
      wait_ack(8, got, edges);
      e = exp_q.pop_front();
      if (got[0]) req[0] = 1'b0;
      n_cmp++; if (got !== (e[2] ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL ptr_grant%0d: got %b want %b", i, got, e[2] ? 2'b10 : 2'b01); end
      n_cmp++; if (rdata !== e[1:0]) begin n_err++; $display("FAIL ptr_rdata%0d: got %b want %b", i, rdata, e[1:0]); end
    end
    req = 2'b00;
  endtask

  task automatic test_short_request();
    logic [1:0] got; int edges, en_cyc, acks0; logic [W-1:0] e;
    idle_cycle();
    acks0 = ack_total;
    set_port(0, 1'b1, 2'd1, 2'b01);
    push_exp(0, 1'b1, 2'd1, 2'b01);
    idle_cycle();
    req[0] = 1'b0;
    addr0 = 2'd3;
    wdata0 = 2'b11;
    wait_ack(8, got, edges);
    e = exp_q.pop_front();
    n_cmp++; if (got !== 2'b01) begin n_err++; $display("FAIL short_ack: got %b want 01", got); end
    n_cmp++; if (edges + 1 !== WR_EDGES) begin n_err++; $display("FAIL short_latency: got %0d want %0d", edges + 1, WR_EDGES); end
    for (int i = 0; i < 6; i++) idle_cycle();
    n_cmp++; if (ack_total - acks0 !== 1) begin n_err++; $display("FAIL short_ack_count: got %0d want 1", ack_total - acks0); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL short_idle: busy got %b want 0", busy); end
    single_access(0, 1'b0, 2'd1, 2'b00, got, edges, en_cyc);
    e = exp_q.pop_front();
    n_cmp++; if (rdata !== e[1:0]) begin n_err++; $display("FAIL short_readback: got %b want %b", rdata, e[1:0]); end
  endtask

  task automatic test_reset_strobe();
    logic [1:0] got; int edges, en_cyc, acks0; logic [W-1:0] e; logic hit;
    idle_cycle();
    acks0 = ack_total;
    set_port(0, 1'b1, 2'd3, 2'b00);
    hit = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idle_cycle();
      if (dbg_state == 3'd2) begin hit = 1'b1; break; end
    end
    n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL rs_reach_strobe: got %b want 1", hit); end
    rst_n = 1'b0;
    req = 2'b00;
    #1;
    n_cmp++; if ({ack, busy, sram_en, sram_cs} !== 5'b00001) begin n_err++; $display("FAIL rs_ctrl: got %b want 00001", {ack, busy, sram_en, sram_cs}); end
    n_cmp++; if ({rdata, sram_addr, sram_d} !== 6'b0) begin n_err++; $display("FAIL rs_data: got %b want 000000", {rdata, sram_addr, sram_d}); end
    n_cmp++; if (dbg_state !== 3'd0) begin n_err++; $display("FAIL rs_state: got %0d want 0", dbg_state); end
    idle_cycle();
    rst_n = 1'b1;
    rdata_model = 2'b00;
    for (int i = 0; i < 4; i++) idle_cycle();
    n_cmp++; if (ack_total - acks0 !== 0) begin n_err++; $display("FAIL rs_no_ack: got %0d want 0", ack_total - acks0); end
    single_access(1, 1'b0, 2'd2, 2'b00, got, edges, en_cyc);
    e = exp_q.pop_front();
    n_cmp++; if (got !== 2'b10) begin n_err++; $display("FAIL rs_after_ack: got %b want 10", got); end
    n_cmp++; if (rdata !== e[1:0]) begin n_err++; $display("FAIL rs_after_rdata: got %b want %b", rdata, e[1:0]); end
  endtask

`ifdef SRAM4X2_WR_VERIFY_EN
  task automatic test_wr_verify();
    logic [1:0] got; int edges, en_cyc; logic [W-1:0] e;
    verify_bad = 1'b1;
    single_access(0, 1'b1, 2'd0, 2'b11, got, edges, en_cyc);
    e = exp_q.pop_front();
    n_cmp++; if ({got, wr_err} !== 3'b011) begin n_err++; $display("FAIL ver_bad: ack,err got %b want 011", {got, wr_err}); end
    n_cmp++; if (edges !== 4) begin n_err++; $display("FAIL ver_latency: got %0d want 4", edges); end
    verify_bad = 1'b0;
    single_access(0, 1'b1, 2'd0, 2'b11, got, edges, en_cyc);
    e = exp_q.pop_front();
    n_cmp++; if ({got, wr_err} !== 3'b010) begin n_err++; $display("FAIL ver_good: ack,err got %b want 010", {got, wr_err}); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_back_to_back();
    test_short_request();
    test_reset_strobe();
`ifdef SRAM4X2_WR_VERIFY_EN
    test_wr_verify();
`endif
    idle_cycle();
    n_cmp++; if (glitch_total !== 0) begin n_err++; $display("FAIL addr_d_stable: changes %0d want 0", glitch_total); end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL queue_drained: left %0d want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
